// File: rtl/game_state_keeper_pkg.sv
// Shared Sokoban constants: update selectors and board-state field layout.
// game_controller imports the same package so both sides agree on encodings.
package sokoban_pkg;

    localparam int STATE_W   = 135;

    localparam int WAY_HI    = 133;
    localparam int WAY_LO    = 70;
    localparam int BOX_HI    = 69;
    localparam int BOX_LO    = 6;
    localparam int PLAYER_HI = 5;
    localparam int PLAYER_LO = 0;

    localparam logic [1:0] SEL_LOAD    = 2'd0;
    localparam logic [1:0] SEL_MOVE    = 2'd1;
    localparam logic [1:0] SEL_RETRACT = 2'd3;

endpackage

// File: rtl/game_state_keeper_if.sv
// Bus between game_controller (master) and game_state_keeper (slave).
interface game_state_keeper_if
    import sokoban_pkg::*;
#(
    parameter int CNT_W = 10
);
    logic               game_state_en;
    logic [1:0]         sel;
    logic [STATE_W-1:0] level_state;
    logic [STATE_W-1:0] move_state;
    logic [STATE_W-1:0] game_state;
    logic               undo_avail;
    logic [CNT_W-1:0]   move_count;

    modport master (
        output game_state_en, sel, level_state, move_state,
        input  game_state, undo_avail, move_count
    );

    modport slave (
        input  game_state_en, sel, level_state, move_state,
        output game_state, undo_avail, move_count
    );
endinterface

// File: rtl/game_state_keeper_state_history.sv
// Circular LIFO of past board states. A push when full overwrites the
// oldest entry; a pop when empty is ignored. The newest entry is read
// combinationally so a retract completes in a single cycle.
module state_history
    import sokoban_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int DEPTH_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [STATE_W-1:0] din,
    output logic [STATE_W-1:0] dout,
    output logic [DEPTH_W-1:0] depth
);
    logic [STATE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Newest entry sits just behind the write pointer (modulo DEPTH).
    always_comb begin
        rd_ptr = wr_ptr - PTR_W'(1);
        dout   = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; clear beats push beats pop.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            depth  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (depth != DEPTH_W'(DEPTH))
                depth <= depth + DEPTH_W'(1);
        end else if (pop && depth != '0) begin
            wr_ptr <= rd_ptr;
            depth  <= depth - DEPTH_W'(1);
        end
    end

    // Storage array is data only and needs no reset.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/game_state_keeper.sv
// Live Sokoban board state with bounded undo history and a move counter.
// LOAD installs a level image, MOVE commits the move result, RETRACT pops
// the previous state. All outputs are registered with one-cycle latency.
module game_state_keeper
    import sokoban_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    game_state_keeper_if.slave  bus
);
    localparam int DEPTH_W = $clog2(DEPTH) + 1;

    logic [STATE_W-1:0] game_state_r;
    logic [STATE_W-1:0] hist_dout;
    logic [DEPTH_W-1:0] depth;
    logic [CNT_W-1:0]   move_count_r;
    logic               undo_avail_r;
    logic               do_load;
    logic               do_move;
    logic               do_retract;

    // Decode the strobe; a retract on an empty history does nothing at all.
    always_comb begin
        do_load    = bus.game_state_en && (bus.sel == SEL_LOAD);
        do_move    = bus.game_state_en && (bus.sel == SEL_MOVE);
        do_retract = bus.game_state_en && (bus.sel == SEL_RETRACT) && (depth != '0);
    end

    state_history #(.DEPTH(DEPTH)) u_history (
        .clk   (clk),
        .reset (reset),
        .push  (do_move),
        .pop   (do_retract),
        .clear (do_load),
        .din   (game_state_r),
        .dout  (hist_dout),
        .depth (depth)
    );

    // Next board state, saturating move counter and undo flag; reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            game_state_r <= '0;
            move_count_r <= '0;
            undo_avail_r <= 1'b0;
        end else if (do_load) begin
            game_state_r <= bus.level_state;
            move_count_r <= '0;
            undo_avail_r <= 1'b0;
        end else if (do_move) begin
            game_state_r <= bus.move_state;
            if (move_count_r != '1)
                move_count_r <= move_count_r + CNT_W'(1);
            undo_avail_r <= 1'b1;
        end else if (do_retract) begin
            game_state_r <= hist_dout;
            if (move_count_r != '0)
                move_count_r <= move_count_r - CNT_W'(1);
            undo_avail_r <= (depth != DEPTH_W'(1));
        end
    end

    assign bus.game_state = game_state_r;
    assign bus.move_count = move_count_r;
    assign bus.undo_avail = undo_avail_r;
endmodule

// File: tb/tb_game_state_keeper.sv
// Directed bench for game_state_keeper: a vector table for load/move/undo
// and corner strobes, plus sequences for wrap-around, reset collision and
// counter saturation (second instance with a 4-bit counter).
module tb_game_state_keeper;
    import sokoban_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic [1:0] sel;
    logic [STATE_W-1:0] lvl;
    logic [STATE_W-1:0] mv;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    game_state_keeper_if #(.CNT_W(10)) bus_a ();
    game_state_keeper_if #(.CNT_W(4))  bus_b ();

    assign bus_a.game_state_en = en;
    assign bus_a.sel           = sel;
    assign bus_a.level_state   = lvl;
    assign bus_a.move_state    = mv;
    assign bus_b.game_state_en = en;
    assign bus_b.sel           = sel;
    assign bus_b.level_state   = lvl;
    assign bus_b.move_state    = mv;

    game_state_keeper #(.DEPTH(8), .CNT_W(10)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    game_state_keeper #(.DEPTH(8), .CNT_W(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // Distinct, nonzero 135-bit board image per index.
    function automatic logic [STATE_W-1:0] st(input int i);
        logic [63:0] a;
        logic [63:0] b;
        a = 64'(i) * 64'h0123_4567_89AB_CDEF + 64'h11;
        b = ~64'(i);
        return {7'(i), a, b};
    endfunction

    typedef struct {
        logic               en;
        logic [1:0]         sel;
        logic [STATE_W-1:0] lvl;
        logic [STATE_W-1:0] mv;
        logic [STATE_W-1:0] exp_gs;
        int                 exp_cnt;
        logic               exp_av;
    } vec_t;

    vec_t vt [$];

    task automatic step(input logic e, input logic [1:0] s,
                        input logic [STATE_W-1:0] l, input logic [STATE_W-1:0] m);
        en  = e;
        sel = s;
        lvl = l;
        mv  = m;
        @(posedge clk);
        #1;
        en  = 1'b0;
    endtask

    task automatic check(input string name, input logic [STATE_W-1:0] gs,
                         input int cnt, input logic av);
        n_cmp++;
        if (bus_a.game_state !== gs || bus_a.move_count !== 10'(cnt) || bus_a.undo_avail !== av) begin
            n_bad++;
            $display("FAIL %s: got gs=%h cnt=%0d av=%b, want gs=%h cnt=%0d av=%b",
                     name, bus_a.game_state, bus_a.move_count, bus_a.undo_avail, gs, cnt, av);
        end
    endtask

    task automatic check_b(input string name, input logic [STATE_W-1:0] gs,
                           input int cnt, input logic av);
        n_cmp++;
        if (bus_b.game_state !== gs || bus_b.move_count !== 4'(cnt) || bus_b.undo_avail !== av) begin
            n_bad++;
            $display("FAIL %s: got gs=%h cnt=%0d av=%b, want gs=%h cnt=%0d av=%b",
                     name, bus_b.game_state, bus_b.move_count, bus_b.undo_avail, gs, cnt, av);
        end
    endtask

    function automatic vec_t v(input logic e, input logic [1:0] s, input int li, input int mi,
                               input int gi, input int cnt, input logic av);
        vec_t r;
        r.en = e; r.sel = s; r.lvl = st(li); r.mv = st(mi);
        r.exp_gs = st(gi); r.exp_cnt = cnt; r.exp_av = av;
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        sel   = SEL_LOAD;
        lvl   = '0;
        mv    = '0;

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", '0, 0, 1'b0);
        check_b("reset_b", '0, 0, 1'b0);
        reset = 1'b0;

        // A=1, B=2, C=3; distractor images use higher indices.
        vt.push_back(v(1, SEL_LOAD,    1, 50, 1, 0, 0));
        vt.push_back(v(1, SEL_MOVE,   51,  2, 2, 1, 1));
        vt.push_back(v(1, SEL_MOVE,   52,  3, 3, 2, 1));
        vt.push_back(v(1, SEL_RETRACT,53, 54, 2, 1, 1));
        vt.push_back(v(1, SEL_RETRACT,55, 56, 1, 0, 0));
        vt.push_back(v(1, SEL_RETRACT,57, 58, 1, 0, 0));
        vt.push_back(v(1, 2'd2,       59,  9, 1, 0, 0));
        vt.push_back(v(0, SEL_MOVE,   60, 10, 1, 0, 0));
        vt.push_back(v(0, SEL_MOVE,   61, 11, 1, 0, 0));
        vt.push_back(v(1, SEL_MOVE,   62,  2, 2, 1, 1));
        vt.push_back(v(1, 2'd2,       63, 12, 2, 1, 1));
        vt.push_back(v(0, SEL_LOAD,   64, 13, 2, 1, 1));
        vt.push_back(v(1, SEL_RETRACT,65, 14, 1, 0, 0));
        vt.push_back(v(1, SEL_MOVE,   66,  3, 3, 1, 1));
        vt.push_back(v(1, SEL_RETRACT,67, 15, 1, 0, 0));
        vt.push_back(v(1, SEL_MOVE,   68,  2, 2, 1, 1));
        vt.push_back(v(1, SEL_LOAD,    3, 16, 3, 0, 0));
        vt.push_back(v(1, SEL_RETRACT,69, 17, 3, 0, 0));

        foreach (vt[i]) begin
            step(vt[i].en, vt[i].sel, vt[i].lvl, vt[i].mv);
            check($sformatf("vec%0d", i), vt[i].exp_gs, vt[i].exp_cnt, vt[i].exp_av);
            check_b($sformatf("vec%0d_b", i), vt[i].exp_gs, vt[i].exp_cnt, vt[i].exp_av);
        end

        // Wrap-around: LOAD S0, MOVE S1..S10, then nine retracts.
        step(1, SEL_LOAD, st(200), st(70));
        check("wrap_load", st(200), 0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1, SEL_MOVE, st(71), st(200 + i));
            check($sformatf("wrap_move%0d", i), st(200 + i), i, 1'b1);
        end
        for (int k = 1; k <= 8; k++) begin
            step(1, SEL_RETRACT, st(72), st(73));
            check($sformatf("wrap_ret%0d", k), st(210 - k), 10 - k, (k != 8));
        end
        step(1, SEL_RETRACT, st(74), st(75));
        check("wrap_ret9", st(202), 2, 1'b0);

        // Reset collides with a MOVE strobe: reset wins.
        step(1, SEL_MOVE, st(76), st(77));
        check("pre_collide", st(77), 3, 1'b1);
        reset = 1'b1;
        step(1, SEL_MOVE, st(78), st(79));
        reset = 1'b0;
        check("collide_a", '0, 0, 1'b0);
        check_b("collide_b", '0, 0, 1'b0);
        step(1, SEL_RETRACT, st(80), st(81));
        check("collide_hist_empty", '0, 0, 1'b0);

        // Counter saturation: 20 moves, then one retract.
        step(1, SEL_LOAD, st(100), st(82));
        for (int i = 1; i <= 20; i++)
            step(1, SEL_MOVE, st(83), st(100 + i));
        check("sat_a", st(120), 20, 1'b1);
        check_b("sat_b", st(120), 15, 1'b1);
        step(1, SEL_RETRACT, st(84), st(85));
        check("sat_ret_a", st(119), 19, 1'b1);
        check_b("sat_ret_b", st(119), 14, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/game_state_keeper.md
# game_state_keeper

Holds the live 135-bit Sokoban board state and a bounded undo history, directly downstream of `game_controller`. On each `game_state_en` pulse it loads a level image, commits a move result or restores the previous state, as selected by `sel`. Its `game_state` output feeds back into `game_controller` and into the render path. It also keeps the move counter shown on the display.

## Interface
- `DEPTH`, 8: undo history entries (power of two, 2..64).
- `CNT_W`, 10: move counter width.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: synchronous, active-high.
- `game_state_en  in  1`: one-cycle update strobe from `game_controller`.
- `sel  in  2`: update source; 0 = LOAD, 1 = MOVE, 3 = RETRACT, 2 = reserved.
- `level_state  in  135`: initial image of the current stage (from stage ROM).
- `move_state  in  135`: next state computed by move logic for the current cursor.
- `game_state  out  135`: live state. Fields: [134] reserved, [133:70] way, [69:6] box, [5:0] player cell.
- `undo_avail  out  1`: history is non-empty.
- `move_count  out  CNT_W`: moves since the last LOAD.

## Operation
- All outputs are registered. Reset values: `game_state` = 0, `undo_avail` = 0, `move_count` = 0, history empty.
- Updates happen only in a cycle where `game_state_en` = 1. Otherwise all state holds.
- **LOAD (sel = 0)**
  - `game_state` ← `level_state`.
  - History cleared: depth = 0.
  - `move_count` ← 0.
- **MOVE (sel = 1)**
  - Push the current `game_state` into history, then `game_state` ← `move_state`.
  - Depth increments, saturating at `DEPTH`.
  - When the history is full, the push overwrites the oldest entry (circular). Depth stays at `DEPTH`.
  - `move_count` increments, saturating at all-ones.
- **RETRACT (sel = 3)**
  - If depth > 0: pop the newest entry into `game_state`, decrement depth, and decrement `move_count` (floored at 0).
  - If depth = 0: no change to any register.
- **sel = 2**: no change to any register; treated as a no-op.
- `undo_avail` = (depth != 0), registered together with depth.
- History is a circular buffer:
  - `wr_ptr` points to the next free slot.
  - Push writes at `wr_ptr` and advances it; pop reads at `wr_ptr - 1` and retreats it. Pointer arithmetic is modulo `DEPTH`.
  - Depth is tracked separately in log2(`DEPTH`)+1 bits.
- Undoing an overwritten move is not possible: after `DEPTH`+k moves, at most `DEPTH` retracts succeed.

## Timing
- Latency is 1 cycle. `game_state`, `undo_avail` and `move_count` reflect an update on the clock edge after the cycle in which `game_state_en` = 1 is sampled.
- Back-to-back strobes on consecutive cycles are legal, and each is applied in order. A MOVE followed by a RETRACT on the next cycle restores the pre-MOVE state.
- History read is combinational from a register array or distributed RAM at `wr_ptr - 1`, so a RETRACT completes in 1 cycle.
- `reset` asserted in the same cycle as `game_state_en`: reset wins and the update is discarded.
- Reset mid-game clears the history. The controller then issues LOAD, since its RESET/INIT states assert `game_state_en` with `sel` = 0.
- `level_state` and `move_state` must be stable in the strobe cycle; they are not registered internally.

## Structure
- **Shared package `sokoban_pkg`:**
  - `SEL_LOAD` = 0, `SEL_MOVE` = 1, `SEL_RETRACT` = 3.
  - Field offsets: `WAY_HI` = 133, `WAY_LO` = 70, `BOX_HI` = 69, `BOX_LO` = 6, `PLAYER_HI` = 5, `PLAYER_LO` = 0.
  - `STATE_W` = 135.
  - `game_controller` uses the same constants.
- **Sub-module `state_history`:**
  - DEPTH×135 circular LIFO.
  - Ports: `clk`, `reset`, `push`, `pop`, `clear`, `din`, `dout`, `depth`.
  - Overwrite-oldest on full; pop on empty is ignored.
- The top level muxes the next `game_state` and runs the counter.

## Test plan
1. **Reset.** Assert reset 2 cycles. Expect `game_state` = 0, `move_count` = 0 and `undo_avail` = 0 on the edge after reset.
2. **Load.** LOAD with `level_state` = A. Expect `game_state` = A one cycle later, `move_count` = 0, `undo_avail` = 0.
3. **Move and undo.**
   - LOAD A, then MOVE B, then MOVE C.
   - Expect `game_state` = C, `move_count` = 2.
   - RETRACT twice. Expect B then A, `move_count` = 1 then 0, and `undo_avail` = 0 after the second retract.
   - A third RETRACT leaves A and 0 unchanged.
4. **Wrap-around.**
   - LOAD S0, then MOVE S1..S10 (`DEPTH` = 8). Expect `move_count` = 10.
   - 8 RETRACTs return S9, S8 … S2.
   - A 9th RETRACT holds at S2 with `move_count` = 2.
5. **Corner strobes.**
   - `sel` = 2 with `game_state_en` = 1: no register changes.
   - `game_state_en` = 0 with `sel` = 1 and a changing `move_state`: no change.
6. **Reset collision and counter saturation.**
   - `reset` and MOVE in the same cycle: expect the reset values.
   - With `CNT_W` = 4, 20 MOVEs: `move_count` saturates at 15, and one RETRACT gives 14.
